sum_serial_sequencer: RTL and testbench
=======================================

SUM_SERIAL_SEQUENCER -- requirements
Module: sum_serial_sequencer

Interface
REQ-001 Parameter N, default 128, operand/result width in bits.
REQ-002 Parameter CC, default 32, number of slice cycles per addition; W = N/CC (default 4) is the slice width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 in_valid  in  1  operand pair offered; in_ready  out  1  sequencer accepts the pair.
REQ-006 in_a, in_b  in  N  operands.
REQ-007 adder_rst  out  1  active-high clear for the downstream serial adder's carry register.
REQ-008 a_slice, b_slice  out  W  current operand slices to the adder; slice_valid  out  1  slices meaningful.
REQ-009 sum_slice  in  W  adder sum output for the current slice, same cycle.
REQ-010 out_valid  out  1  result available; out_ready  in  1  consumer takes the result; result  out  N  sum mod 2^N.

Function
REQ-011 The block SHALL implement FSM states IDLE, CLEAR, RUN, DONE.
REQ-012 IDLE: in_ready=1; on in_valid&in_ready, latch in_a/in_b into shift registers and go to CLEAR.
REQ-013 CLEAR (1 cycle): adder_rst=1, slice_valid=0, slices=0; next state RUN with slice counter=0.
REQ-014 RUN: slice_valid=1; a_slice/b_slice = bits [W-1:0] of the shift registers; shift registers shift right by W each cycle; counter increments.
REQ-015 RUN: each cycle the result register SHALL shift right by W with sum_slice inserted at bits [N-1:N-W], so slice k lands at bits [kW+W-1:kW] after CC cycles.
REQ-016 On counter = CC-1 in RUN, the next state SHALL be DONE.
REQ-017 DONE: out_valid=1, result held stable; on out_ready go to IDLE; out_valid stays high while out_ready=0.
REQ-018 in_ready SHALL be 0 in CLEAR, RUN, DONE; no operand accepted outside IDLE.
REQ-019 Latency: handshake at edge t -> CLEAR in cycle t+1, RUN cycles t+2..t+CC+1, out_valid from cycle t+CC+2.
REQ-020 Carry-out beyond bit N-1 SHALL be discarded (wrap-around mod 2^N).
REQ-021 Minimum back-to-back period: CC+3 cycles (accept, CLEAR, CC RUN, DONE with out_ready=1, IDLE accept).
REQ-022 Counter width SHALL be ceil(log2(CC)); CC SHALL divide N (elaboration check).
REQ-023 in_a/in_b changes outside the accept cycle SHALL have no effect.

Reset
REQ-024 While rst=0 at a rising edge: state=IDLE, counter=0, shift and result registers=0.
REQ-025 adder_rst SHALL be 1 while rst=0 and in CLEAR, else 0.
REQ-026 Outputs after reset: in_ready=1, out_valid=0, slice_valid=0, a_slice=b_slice=0, result=0.
REQ-027 Reset mid-RUN or in DONE SHALL abort the operation; no out_valid for the aborted pair.

Structure
REQ-028 A shared package sum_pkg SHALL hold default N, CC, derived W, counter width, and the FSM state enum.
REQ-029 No sub-module; the serial adder is instantiated alongside at the parent level, sum_slice driven from its c output, its carry reset from adder_rst.

Verification
REQ-030 a=1, b=1 -> result=2, out_valid at cycle t+34 (N=128, CC=32).
REQ-031 a=2^128-1, b=1 -> result=0 (carry ripples through all 32 slices, discarded).
REQ-032 a=0x0F, b=0x01 -> result=0x10 (cross-slice carry into slice 1).
REQ-033 out_ready held 0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-034 rst=0 at RUN slice 15, then second pair a=5, b=7 -> only result=12 reported; adder_rst=1 during reset and CLEAR.
REQ-035 Two pairs back-to-back with out_ready=1 -> both sums correct, second accept exactly 35 cycles after first.

Source files
------------

// File: rtl/sum_pkg.sv
// -----------------------------------------------------------------------------
// sum_pkg
// Shared definitions for the bit-serial sum sequencer: default operand width,
// slice-cycle count, derived slice and counter widths, and the FSM state type.
// -----------------------------------------------------------------------------
package sum_pkg;

    localparam int N_DEFAULT  = 128;
    localparam int CC_DEFAULT = 32;
    localparam int W_DEFAULT  = N_DEFAULT / CC_DEFAULT;

    // Slice counter width: ceil(log2(cc)), kept at least 1 bit so the
    // counter stays a legal vector when only one slice cycle is configured.
    function automatic int cnt_width(input int cc);
        return (cc > 1) ? $clog2(cc) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(CC_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sum_serial_sequencer.sv
// -----------------------------------------------------------------------------
// sum_serial_sequencer
// Feeds an external W-bit serial adder one operand slice per cycle and
// reassembles the N-bit sum. One addition takes CC slice cycles, preceded by
// a one-cycle carry clear. The carry out of the top slice is discarded, so
// the result is (a + b) mod 2^N.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-low reset
//   in_valid    in   operand pair offered
//   in_ready    out  pair accepted this cycle (IDLE only)
//   in_a, in_b  in   N-bit operands
//   adder_rst   out  active-high clear for the serial adder's carry register
//   a_slice     out  current W-bit slice of a (0 outside RUN)
//   b_slice     out  current W-bit slice of b (0 outside RUN)
//   slice_valid out  slices are meaningful (RUN)
//   sum_slice   in   adder sum for the current slices, same cycle
//   out_valid   out  result available (DONE)
//   out_ready   in   consumer takes the result
//   result      out  N-bit sum
// -----------------------------------------------------------------------------
module sum_serial_sequencer
    import sum_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CC = CC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             adder_rst,
    output logic [N/CC-1:0]  a_slice,
    output logic [N/CC-1:0]  b_slice,
    output logic             slice_valid,
    input  logic [N/CC-1:0]  sum_slice,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     result
);

    localparam int W     = N / CC;
    localparam int CNT_W = cnt_width(CC);

    // A width that the slice count does not divide would silently drop the
    // top bits, so refuse to elaborate.
    if ((CC < 1) || ((N % CC) != 0)) begin : g_bad_cfg
        $error("sum_serial_sequencer: CC must be >= 1 and divide N");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_result;
    logic               w_accept;
    logic               w_last_slice;

    assign w_accept     = in_valid && in_ready;
    assign w_last_slice = (r_cnt == CNT_W'(CC - 1));

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: every register here is reset, including the wide shift and result
    // registers, because result is visible on the port straight out of reset
    // and must read 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    // Operands are sampled only on the accept edge; later
                    // changes on in_a/in_b are ignored.
                    if (w_accept) begin
                        r_a <= in_a;
                        r_b <= in_b;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= '0;
                end
                ST_RUN: begin
                    r_a   <= r_a >> W;
                    r_b   <= r_b >> W;
                    // New slice enters at the top; after CC shifts slice k
                    // sits at bits [kW+W-1:kW].
                    r_result <= (r_result >> W) | (N'(sum_slice) << (N - W));
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Next state and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        in_ready     = 1'b0;
        slice_valid  = 1'b0;
        out_valid    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                slice_valid = 1'b1;
                if (w_last_slice) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Slices are forced to zero outside RUN so the adder never sees the
    // freshly latched operands during CLEAR.
    assign a_slice   = slice_valid ? r_a[W-1:0] : '0;
    assign b_slice   = slice_valid ? r_b[W-1:0] : '0;
    // Carry clear follows the reset input directly so the adder is held
    // cleared for the whole time reset is asserted.
    assign adder_rst = !rst || (r_state == ST_CLEAR);
    assign result    = r_result;

endmodule

// File: tb/tb_sum_serial_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sum_serial_sequencer
// Directed bench for sum_serial_sequencer at N=128, CC=32 (W=4). A small
// behavioural 4-bit serial adder with a carry register sits beside the DUT,
// driven by a_slice/b_slice and cleared by adder_rst.
// -----------------------------------------------------------------------------
module tb_sum_serial_sequencer;

    localparam int N  = 128;
    localparam int CC = 32;
    localparam int W  = N / CC;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          adder_rst;
    logic [W-1:0]  a_slice;
    logic [W-1:0]  b_slice;
    logic          slice_valid;
    logic [W-1:0]  sum_slice;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial adder alongside the sequencer
    logic          carry;
    logic [W:0]    add_full;
    assign add_full  = {1'b0, a_slice} + {1'b0, b_slice} + {{W{1'b0}}, carry};
    assign sum_slice = add_full[W-1:0];
    always_ff @(posedge clk) begin
        if (adder_rst)        carry <= 1'b0;
        else if (slice_valid) carry <= add_full[W];
    end

    sum_serial_sequencer #(.N(N), .CC(CC)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .adder_rst   (adder_rst),
        .a_slice     (a_slice),
        .b_slice     (b_slice),
        .slice_valid (slice_valid),
        .sum_slice   (sum_slice),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair, follow it through CLEAR/RUN/DONE, hold out_ready low for
    // 'hold' cycles in DONE, then release it. Returns the accept cycle.
    task automatic run_pair(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] exp, input int hold, output int acc_cyc);
        int lat;
        bit run_bad;
        bit stall_bad;
        check({tag, " in_ready_idle"}, N'(in_ready), N'(1));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();                              // accept edge t
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_a     = ~a;                       // must not disturb the operation
        in_b     = {N{1'b1}};
        // cycle t+1 : CLEAR
        check({tag, " clear_ctl"}, N'({adder_rst, slice_valid, in_ready, a_slice, b_slice}),
              N'({1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}));
        lat     = 1;
        run_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
            if (!out_valid && (!slice_valid || in_ready || adder_rst)) run_bad = 1'b1;
        end
        check({tag, " run_ctl"}, N'(run_bad), N'(0));
        check({tag, " latency"}, N'(lat), N'(34));
        check({tag, " result"}, result, exp);
        stall_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!out_valid || in_ready || result !== exp) stall_bad = 1'b1;
        end
        if (hold > 0) check({tag, " stall_stable"}, N'(stall_bad), N'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " back_to_idle"}, N'({in_ready, out_valid}), N'({1'b1, 1'b0}));
    endtask

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc0;
        int acc1;
        int acc2;

        vecs[0] = '{"one_plus_one", 128'd1, 128'd1, 128'd2, 0};
        vecs[1] = '{"full_wrap", {128{1'b1}}, 128'd1, 128'd0, 0};
        vecs[2] = '{"cross_slice", 128'h0F, 128'h01, 128'h10, 0};
        vecs[3] = '{"stall10", 128'h1234, 128'h4321, 128'h5555, 10};
        vecs[4] = '{"alt_bits", {32{4'hA}}, {32{4'h5}}, {128{1'b1}}, 0};
        vecs[5] = '{"top_carry_drop", {1'b1, 127'd0}, {1'b1, 127'd0}, 128'd0, 0};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_adder_rst", N'(adder_rst), N'(1));
        check("reset_outputs", N'({in_ready, out_valid, slice_valid, a_slice, b_slice}),
              N'({1'b1, 1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}}));
        check("reset_result", result, '0);
        rst = 1'b1;
        tick();
        check("adder_rst_released", N'(adder_rst), N'(0));

        // Table-driven pairs, each started as soon as the previous is done
        for (int i = 0; i < 6; i++) begin
            run_pair(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, acc0);
        end

        // Reset during RUN slice 15, then a fresh pair
        in_valid = 1'b1;
        in_a     = 128'hDEAD_BEEF;
        in_b     = 128'h1;
        tick();                              // accept edge t
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick(); // now in cycle t+17 = slice 15
        check("abort_in_slice15", N'(slice_valid), N'(1));
        rst = 1'b0;
        #1;
        check("abort_adder_rst", N'(adder_rst), N'(1));
        tick();
        tick();
        check("abort_state", N'({in_ready, out_valid, slice_valid}), N'({1'b1, 1'b0, 1'b0}));
        check("abort_result", result, '0);
        rst = 1'b1;
        begin
            bit ghost = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid) ghost = 1'b1;
            end
            check("abort_no_out_valid", N'(ghost), N'(0));
        end
        run_pair("after_abort", 128'd5, 128'd7, 128'd12, 0, acc0);

        // Back-to-back: second accept exactly CC+3 cycles after the first
        run_pair("b2b_first", 128'hFF, 128'h01, 128'h100, 0, acc1);
        run_pair("b2b_second", 128'd100, 128'd23, 128'd123, 0, acc2);
        check("b2b_period", N'(acc2 - acc1), N'(35));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
